// File: rtl/wb_sram_gen_if.sv
// Wishbone classic slave-side bundle for wb_sram_gen: 32-bit data, byte selects, single-cycle ack.
interface wb_sram_gen_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_sram_gen.sv
// Wishbone slave to async SRAM bridge: each 32-bit access becomes 32/SRAM_DW SRAM beats.
// Optional one-word read buffer when WB_SRAM_GEN_RDBUF_EN is defined.
module wb_sram_gen #(
  parameter int ADR_W   = 18,
  parameter int SRAM_DW = 16,
  parameter int RD_WAIT = 0,
  parameter int WR_WAIT = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  wb_sram_gen_if.slave         wb,
  output logic [ADR_W-1:0]     sram_adr,
  inout  wire  [SRAM_DW-1:0]   sram_dat,
  output logic [SRAM_DW/8-1:0] sram_be_n,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);
  localparam int BPB = SRAM_DW / 8;
  localparam int NB  = 32 / SRAM_DW;
  localparam int AB  = $clog2(BPB);

  generate
    if (!(SRAM_DW == 8 || SRAM_DW == 16 || SRAM_DW == 32)) begin : g_bad_dw
      $error("wb_sram_gen: SRAM_DW must be 8, 16 or 32");
    end
    if (RD_WAIT < 0 || RD_WAIT > 7 || WR_WAIT < 0 || WR_WAIT > 7) begin : g_bad_wait
      $error("wb_sram_gen: RD_WAIT/WR_WAIT must be 0..7");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, RD, WR_SU, WR_P, WR_H, ACK} state_t;

  state_t      state_q, state_d;
  logic [1:0]  beat_q, beat_d;
  logic [2:0]  wait_q, wait_d;
  logic [31:0] rdat_q, rdat_d;
  logic [2:0]  nb;
  logic        req, buf_hit;
  logic [31:0] buf_dat;
  logic [ADR_W-1:0]   word_adr, beat_adr;
  logic [SRAM_DW-1:0] wdat;
  logic [BPB-1:0]     lane_sel;
  logic               drv, unused_adr;

  // First beat at or after 'from' whose byte-select lane is non-zero; NB when none remain.
  function automatic logic [2:0] next_beat(input logic [3:0] sel, input logic [2:0] from);
    logic [2:0] r;
    r = 3'(NB);
    for (int i = NB - 1; i >= 0; i--)
      if (3'(i) >= from && |sel[i*BPB +: BPB]) r = 3'(i);
    return r;
  endfunction

  assign req        = wb.wb_stb_i & wb.wb_cyc_i & ~wb.wb_ack_o;
  assign word_adr   = wb.wb_adr_i[ADR_W+AB-1:AB];
  assign beat_adr   = (word_adr & ~ADR_W'(NB - 1)) | ADR_W'(beat_q);
  assign wdat       = wb.wb_dat_i[int'(beat_q)*SRAM_DW +: SRAM_DW];
  assign lane_sel   = wb.wb_sel_i[int'(beat_q)*BPB +: BPB];
  assign drv        = (state_q == WR_SU) || (state_q == WR_P) || (state_q == WR_H);
  assign sram_dat   = drv ? wdat : 'z;
  assign wb.wb_ack_o = (state_q == ACK);
  assign wb.wb_dat_o = rdat_q;
  assign unused_adr = ^wb.wb_adr_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      wait_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      rdat_q  <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    rdat_d  = rdat_q;
    nb      = '0;
    case (state_q)
      IDLE: if (req) begin
        beat_d = '0;
        wait_d = '0;
        if (wb.wb_we_i) begin
          nb = next_beat(wb.wb_sel_i, 3'd0);
          if (nb == 3'(NB)) state_d = ACK;
          else begin
            beat_d  = nb[1:0];
            state_d = WR_SU;
          end
        end else if (buf_hit) begin
          rdat_d  = buf_dat;
          state_d = ACK;
        end else begin
          state_d = RD;
        end
      end
      RD: if (wait_q == 3'(RD_WAIT)) begin
        rdat_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = sram_dat;
        wait_d = '0;
        if (beat_q == 2'(NB - 1)) state_d = ACK;
        else beat_d = beat_q + 2'd1;
      end else begin
        wait_d = wait_q + 3'd1;
      end
      WR_SU: begin
        state_d = WR_P;
        wait_d  = '0;
      end
      WR_P: if (wait_q == 3'(WR_WAIT)) state_d = WR_H;
            else wait_d = wait_q + 3'd1;
      WR_H: begin
        nb = next_beat(wb.wb_sel_i, {1'b0, beat_q} + 3'd1);
        if (nb == 3'(NB)) state_d = ACK;
        else begin
          beat_d  = nb[1:0];
          state_d = WR_SU;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pins decode straight from registered state so reset releases the SRAM in the same cycle.
  always_comb begin
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = '1;
    sram_adr  = '0;
    case (state_q)
      RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        sram_be_n = '0;
        sram_adr  = beat_adr;
      end
      WR_SU, WR_H: begin
        sram_ce_n = 1'b0;
        sram_be_n = ~lane_sel;
        sram_adr  = beat_adr;
      end
      WR_P: begin
        sram_ce_n = 1'b0;
        sram_we_n = 1'b0;
        sram_be_n = ~lane_sel;
        sram_adr  = beat_adr;
      end
      default: ;
    endcase
  end

`ifdef WB_SRAM_GEN_RDBUF_EN
  logic        buf_vld_q;
  logic [29:0] buf_adr_q;
  logic [31:0] buf_dat_q;

  assign buf_hit = buf_vld_q && (buf_adr_q == wb.wb_adr_i[31:2]);
  assign buf_dat = buf_dat_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_vld_q <= 1'b0;
      buf_adr_q <= '0;
      buf_dat_q <= '0;
    end else if (state_q == RD && state_d == ACK) begin
      buf_vld_q <= 1'b1;
      buf_adr_q <= wb.wb_adr_i[31:2];
      buf_dat_q <= rdat_d;
    end else if (state_q == IDLE && req && wb.wb_we_i && buf_hit) begin
      // Keep the buffer coherent with writes to the same word.
      for (int b = 0; b < 4; b++)
        if (wb.wb_sel_i[b]) buf_dat_q[b*8 +: 8] <= wb.wb_dat_i[b*8 +: 8];
    end
  end
`else
  assign buf_hit = 1'b0;
  assign buf_dat = '0;
`endif
endmodule

// File: tb/tb_wb_sram_gen.sv
// Self-checking bench for wb_sram_gen (16-bit SRAM, 2 read waits, 1 write wait) with a behavioural SRAM.
module tb_wb_sram_gen;
  localparam int DW  = 16;
  localparam int RDW = 2;
  localparam int WRW = 1;
  localparam int NB  = 32 / DW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  wb_sram_gen_if wb();
  logic [17:0] sram_adr;
  wire  [15:0] sram_dat;
  logic [1:0]  sram_be_n;
  logic        sram_ce_n, sram_oe_n, sram_we_n;

  wb_sram_gen #(.ADR_W(18), .SRAM_DW(DW), .RD_WAIT(RDW), .WR_WAIT(WRW)) dut (
    .clk(clk), .reset_n(reset_n), .wb(wb),
    .sram_adr(sram_adr), .sram_dat(sram_dat), .sram_be_n(sram_be_n),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  logic [15:0] mem [0:1023];
  bit          mem_init = 1'b0;
  int ce_cnt = 0, oe_cnt = 0, we_cnt = 0, pulse_cnt = 0, viol_cnt = 0;
  logic prev_we = 1'b1;

  assign sram_dat = (!sram_ce_n && !sram_oe_n && sram_we_n) ? mem[sram_adr[9:0]] : 'z;

  // SRAM model + pin activity monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
      mem[10'h080] = 16'h1234; mem[10'h081] = 16'hABCD;
      mem[10'h020] = 16'h7788; mem[10'h021] = 16'h99AA;
      mem_init = 1'b1;
    end
    if (!sram_ce_n) ce_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n) we_cnt++;
    if (!sram_we_n && prev_we) pulse_cnt++;
    prev_we = sram_we_n;
    if (!sram_oe_n && (!sram_we_n || sram_ce_n)) viol_cnt++;
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 2; b++)
        if (!sram_be_n[b]) mem[sram_adr[9:0]][b*8 +: 8] = sram_dat[b*8 +: 8];
  end

  int checks = 0, errors = 0;
  logic [31:0] sb[$];
  bit          mbuf_vld = 1'b0;
  logic [29:0] mbuf_adr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic txn(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [31:0] exp_dat, input int pulses);
    int lat, c0, o0, w0, p0, exp_lat, exp_ce, exp_oe, exp_we;
    bit hit;
    logic [31:0] q;
    hit = 1'b0;
`ifdef WB_SRAM_GEN_RDBUF_EN
    hit = !we && mbuf_vld && (mbuf_adr == adr[31:2]);
    if (!we) begin mbuf_vld = 1'b1; mbuf_adr = adr[31:2]; end
`endif
    if (we) begin
      exp_lat = pulses * (3 + WRW) + 1;
      exp_ce  = pulses * (3 + WRW);
      exp_oe  = 0;
      exp_we  = pulses * (1 + WRW);
    end else begin
      exp_lat = hit ? 1 : NB * (1 + RDW) + 1;
      exp_ce  = hit ? 0 : NB * (1 + RDW);
      exp_oe  = exp_ce;
      exp_we  = 0;
      sb.push_back(exp_dat);
    end
    @(posedge clk); #1;
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = we;
    wb.wb_adr_i = adr;  wb.wb_sel_i = sel;  wb.wb_dat_i = dat;
    c0 = ce_cnt; o0 = oe_cnt; w0 = we_cnt; p0 = pulse_cnt;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wb.wb_ack_o && lat < 50);
    check($sformatf("latency %h", adr), 32'(lat), 32'(exp_lat));
    if (!we) begin
      q = sb.pop_front();
      check($sformatf("rdata %h", adr), wb.wb_dat_o, q);
    end
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
    check($sformatf("ce_cycles %h", adr), 32'(ce_cnt - c0), 32'(exp_ce));
    check($sformatf("oe_cycles %h", adr), 32'(oe_cnt - o0), 32'(exp_oe));
    check($sformatf("we_cycles %h", adr), 32'(we_cnt - w0), 32'(exp_we));
    if (we) check($sformatf("we_pulses %h", adr), 32'(pulse_cnt - p0), 32'(pulses));
    @(posedge clk); #1;
    check("ack_single_cycle", {31'b0, wb.wb_ack_o}, 32'h0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp;
    int          pulses;
  } vec_t;
  vec_t tbl[16];

  initial begin
    int n;
    bit ack_seen;
    tbl[0]  = '{1'b0, 32'h100, 4'hF, 32'h0,        32'hABCD1234, 0};
    tbl[1]  = '{1'b1, 32'h200, 4'hF, 32'hDEADBEEF, 32'h0,        2};
    tbl[2]  = '{1'b0, 32'h200, 4'hF, 32'h0,        32'hDEADBEEF, 0};
    tbl[3]  = '{1'b1, 32'h200, 4'hA, 32'h11223344, 32'h0,        2};
    tbl[4]  = '{1'b0, 32'h200, 4'hF, 32'h0,        32'h11AD33EF, 0};
    tbl[5]  = '{1'b1, 32'h200, 4'hC, 32'h55667788, 32'h0,        1};
    tbl[6]  = '{1'b0, 32'h200, 4'hF, 32'h0,        32'h556633EF, 0};
    tbl[7]  = '{1'b1, 32'h200, 4'h0, 32'hFFFFFFFF, 32'h0,        0};
    tbl[8]  = '{1'b0, 32'h204, 4'hF, 32'h0,        32'h00000000, 0};
    tbl[9]  = '{1'b0, 32'h200, 4'hF, 32'h0,        32'h556633EF, 0};
    tbl[10] = '{1'b1, 32'h104, 4'h3, 32'hCAFEF00D, 32'h0,        1};
    tbl[11] = '{1'b0, 32'h104, 4'hF, 32'h0,        32'h0000F00D, 0};
    tbl[12] = '{1'b0, 32'h100, 4'hF, 32'h0,        32'hABCD1234, 0};
    tbl[13] = '{1'b0, 32'h040, 4'hF, 32'h0,        32'h99AA7788, 0};
    tbl[14] = '{1'b1, 32'h040, 4'h1, 32'h00000055, 32'h0,        1};
    tbl[15] = '{1'b0, 32'h040, 4'hF, 32'h0,        32'h99AA7755, 0};

    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0; wb.wb_we_i = 1'b0;
    wb.wb_adr_i = '0;   wb.wb_sel_i = '0;   wb.wb_dat_i = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ce_n", {31'b0, sram_ce_n}, 32'h1);
    check("reset oe_we_be", {28'b0, sram_oe_n, sram_we_n, sram_be_n}, 32'hF);
    check("reset sram_adr", {14'b0, sram_adr}, 32'h0);
    check("reset ack_dat", wb.wb_dat_o | {31'b0, wb.wb_ack_o}, 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++)
      txn(tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, tbl[i].exp, tbl[i].pulses);

    // Reset asserted in the middle of a write pulse.
    @(posedge clk); #1;
    wb.wb_stb_i = 1'b1; wb.wb_cyc_i = 1'b1; wb.wb_we_i = 1'b1;
    wb.wb_adr_i = 32'h300; wb.wb_sel_i = 4'hF; wb.wb_dat_i = 32'h12345678;
    n = 0;
    while (sram_we_n && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach WR_P", {31'b0, sram_we_n}, 32'h0);
    reset_n = 1'b0;
    #1;
    check("midreset we_n", {31'b0, sram_we_n}, 32'h1);
    check("midreset ce_n", {31'b0, sram_ce_n}, 32'h1);
    check("midreset be_adr", {12'b0, sram_be_n, sram_adr}, {12'b0, 2'b11, 18'h0});
    check("midreset dat_o", wb.wb_dat_o, 32'h0);
    wb.wb_stb_i = 1'b0; wb.wb_cyc_i = 1'b0;
    ack_seen = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o) ack_seen = 1'b1;
    end
    reset_n = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (wb.wb_ack_o) ack_seen = 1'b1;
    end
    check("no ack after reset", {31'b0, ack_seen}, 32'h0);
    mbuf_vld = 1'b0;
    txn(1'b0, 32'h100, 4'hF, 32'h0, 32'hABCD1234, 0);
    txn(1'b0, 32'h040, 4'hF, 32'h0, 32'h99AA7755, 0);

    check("oe/we overlap", 32'(viol_cnt), 32'h0);
    check("scoreboard empty", 32'(sb.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
